// File: rtl/p_perm_pipe.sv
// rtl/p_perm_pipe.sv - pipelined per-lane DES P / P-inverse permutation with valid/ready stall chain
//
// Purpose:
//   Applies the 32-bit DES P permutation (or its inverse) to each 32-bit lane
//   of a LANES*32-bit word. Lanes with their bypass bit set pass through
//   unchanged. The result moves through PIPE register stages under a
//   valid/ready handshake, at up to one transfer per cycle.
//
// Parameters:
//   LANES      number of 32-bit lanes (1..8), W = 32*LANES
//   PIPE       number of register stages (1..4)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   P_in       input word, lane i at bits [32*i+31:32*i]
//   in_valid   P_in / in_mode / in_bypass are valid
//   in_ready   first stage can accept this cycle
//   in_mode    0 = forward P, 1 = inverse P (applies to all lanes)
//   in_bypass  per-lane bypass, 1 = lane copied unpermuted
//   P_out      permuted word from the last stage
//   out_valid  P_out holds a result
//   out_ready  downstream accepts P_out
//   xfer_cnt   completed output transfers, saturating at 16'hFFFF

module p_perm_pipe #(
   parameter int LANES = 2,
   parameter int PIPE  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [32*LANES-1:0]   P_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_mode,
   input  logic [LANES-1:0]      in_bypass,
   output logic [32*LANES-1:0]   P_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [15:0]           xfer_cnt
);

   localparam int W = 32 * LANES;

   // DES P table, 1-indexed, entry k names the source bit (MSB = bit 1)
   // feeding output position k+1.
   function automatic logic [5:0] p_entry(input int k);
      logic [5:0] e;
      case (k)
         0:  e = 6'd16;  1:  e = 6'd7;   2:  e = 6'd20;  3:  e = 6'd21;
         4:  e = 6'd29;  5:  e = 6'd12;  6:  e = 6'd28;  7:  e = 6'd17;
         8:  e = 6'd1;   9:  e = 6'd15;  10: e = 6'd23;  11: e = 6'd26;
         12: e = 6'd5;   13: e = 6'd18;  14: e = 6'd31;  15: e = 6'd10;
         16: e = 6'd2;   17: e = 6'd8;   18: e = 6'd24;  19: e = 6'd14;
         20: e = 6'd32;  21: e = 6'd27;  22: e = 6'd3;   23: e = 6'd9;
         24: e = 6'd19;  25: e = 6'd13;  26: e = 6'd30;  27: e = 6'd6;
         28: e = 6'd22;  29: e = 6'd11;  30: e = 6'd4;   default: e = 6'd25;
      endcase
      return e;
   endfunction

   // Forward: out[31-k] = in[32-P[k]]. Inverse scatters the same wiring
   // the other way round, so forward followed by inverse is identity.
   function automatic logic [31:0] lane_perm(input logic [31:0] x, input logic inv);
      logic [31:0] o;
      logic [5:0]  src;
      o = '0;
      for (int k = 0; k < 32; k++) begin
         src = 6'd32 - p_entry(k);
         if (inv)
            o[src[4:0]] = x[31-k];
         else
            o[31-k] = x[src[4:0]];
      end
      return o;
   endfunction

   logic [W-1:0]    perm_d;
   logic [W-1:0]    d [PIPE];
   logic [PIPE-1:0] v;
   logic [PIPE-1:0] rdy;
   logic            acc;

   always_comb begin
      perm_d = '0;
      for (int i = 0; i < LANES; i++) begin
         if (in_bypass[i])
            perm_d[32*i +: 32] = P_in[32*i +: 32];
         else
            perm_d[32*i +: 32] = lane_perm(P_in[32*i +: 32], in_mode);
      end
   end

   // Stall chain: a stage may load when it is empty or the stage after it
   // can load. Built from the output end as a plain OR chain so the only
   // path from out_ready to in_ready is through these gates.
   always_comb begin
      rdy = '0;
      acc = out_ready;
      for (int k = PIPE - 1; k >= 0; k--) begin
         acc    = acc | ~v[k];
         rdy[k] = acc;
      end
   end

   // Data registers only capture when the incoming slot is valid, so a
   // bubble never disturbs the last value shown on P_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v        <= '0;
         xfer_cnt <= '0;
         for (int k = 0; k < PIPE; k++)
            d[k] <= '0;
      end else begin
         if (rdy[0]) begin
            v[0] <= in_valid;
            if (in_valid)
               d[0] <= perm_d;
         end
         for (int k = 1; k < PIPE; k++) begin
            if (rdy[k]) begin
               v[k] <= v[k-1];
               if (v[k-1])
                  d[k] <= d[k-1];
            end
         end
         if (v[PIPE-1] && out_ready && (xfer_cnt != 16'hFFFF))
            xfer_cnt <= xfer_cnt + 16'd1;
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = v[PIPE-1];
   assign P_out     = d[PIPE-1];

endmodule

// File: tb/tb_p_perm_pipe.sv
// tb/tb_p_perm_pipe.sv - scoreboard bench for p_perm_pipe (LANES=2, PIPE=2)

module tb_p_perm_pipe;

   localparam int LANES = 2;
   localparam int PIPE  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] P_in = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_mode = 1'b0;
   logic [1:0]  in_bypass = '0;
   logic [63:0] P_out;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] xfer_cnt;

   int n_chk = 0;
   int n_err = 0;
   int n_out = 0;
   bit sb_on = 1'b1;
   logic [63:0] exp_q[$];

   int ptab [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                     2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

   p_perm_pipe #(.LANES(LANES), .PIPE(PIPE)) dut (
      .clk       (clk),
      .rst       (rst),
      .P_in      (P_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_bypass (in_bypass),
      .P_out     (P_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .xfer_cnt  (xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_lane(input logic [31:0] x, input logic inv);
      logic [31:0] o;
      o = '0;
      for (int k = 0; k < 32; k++) begin
         if (!inv) o[31-k] = x[32-ptab[k]];
         else      o[32-ptab[k]] = x[31-k];
      end
      return o;
   endfunction

   function automatic logic [63:0] m_word(input logic [63:0] x, input logic inv, input logic [1:0] byp);
      logic [63:0] o;
      for (int i = 0; i < 2; i++)
         o[32*i +: 32] = byp[i] ? x[32*i +: 32] : m_lane(x[32*i +: 32], inv);
      return o;
   endfunction

   // Scoreboard: every observed output transfer is matched in order
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_out++;
         if (sb_on) begin
            chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0)
               chk("sb_data", P_out, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [63:0] x, input logic mode, input logic [1:0] byp,
                       input logic [63:0] exp);
      int t;
      P_in = x; in_mode = mode; in_bypass = byp; in_valid = 1'b1;
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(exp);
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         t++;
         if (t > 1000) begin
            chk("send_timeout", 64'(t), 64'd0);
            break;
         end
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [63:0] x, f, hold;
      logic [1:0]  b;
      logic        m;
      time         t0;
      int          base, t;
      bit          done;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_pout", P_out, 64'd0);
      chk("rst_cnt", 64'(xfer_cnt), 64'd0);
      chk("rst_inrdy", 64'(in_ready), 64'd1);
      rst = 1'b0;

      // Known vector, latency and first count
      send(64'h80000000_00000001, 1'b0, 2'b00, 64'h00800000_00000800);
      idle();
      @(negedge clk);
      chk("lat_early", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("fwd_vec", P_out, 64'h00800000_00000800);
      @(posedge clk); #1;
      chk("cnt_one", 64'(xfer_cnt), 64'd1);

      send(64'h00800000_00000800, 1'b1, 2'b00, 64'h80000000_00000001);
      send(64'h80000000_80000000, 1'b0, 2'b10, 64'h80000000_00800000);
      send(64'h01234567_89ABCDEF, 1'b1, 2'b11, 64'h01234567_89ABCDEF);
      idle();
      drain();

      // Random round trips at full throughput
      t0 = $time;
      for (int i = 0; i < 1000; i++) begin
         x = {$urandom, $urandom};
         f = m_word(x, 1'b0, 2'b00);
         send(x, 1'b0, 2'b00, f);
         send(f, 1'b1, 2'b00, x);
      end
      chk("throughput", 64'(($time - t0) / 10), 64'd2000);
      idle();
      drain();

      // Random mode/bypass with random backpressure
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               x = {$urandom, $urandom};
               m = 1'($urandom_range(0, 1));
               b = 2'($urandom_range(0, 3));
               send(x, m, b, m_word(x, m, b));
            end
            idle();
            done = 1'b1;
         end
         begin
            while (!done) begin
               out_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Stream 0..9 with a stall window on cycles 3..7
      do_reset();
      fork
         begin
            for (int i = 0; i < 10; i++)
               send(64'(i), 1'b0, 2'b00, m_word(64'(i), 1'b0, 2'b00));
            idle();
         end
         begin
            hold = '0;
            for (int c = 0; c < 16; c++) begin
               out_ready = !(c >= 3 && c <= 7);
               @(negedge clk);
               if (c == 4) hold = P_out;
               if (c == 7) begin
                  chk("stall_inrdy", 64'(in_ready), 64'd0);
                  chk("stall_valid", 64'(out_valid), 64'd1);
                  chk("stall_hold", P_out, hold);
               end
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_cnt", 64'(xfer_cnt), 64'd10);

      // Reset with two items in flight
      out_ready = 1'b0;
      send(64'h11111111_22222222, 1'b0, 2'b00, 64'h0);
      send(64'h33333333_44444444, 1'b0, 2'b00, 64'h0);
      idle();
      chk("flight_valid", 64'(out_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_cnt", 64'(xfer_cnt), 64'd0);
      chk("mid_rst_inrdy", 64'(in_ready), 64'd1);
      exp_q.delete();
      rst = 1'b0;
      out_ready = 1'b1;
      x = 64'hDEADBEEF_CAFEF00D;
      send(x, 1'b0, 2'b00, m_word(x, 1'b0, 2'b00));
      idle();
      drain();
      chk("post_rst_cnt", 64'(xfer_cnt), 64'd1);

      // Saturation of the transfer counter
      do_reset();
      sb_on = 1'b0;
      base = n_out;
      P_in = '0; in_mode = 1'b0; in_bypass = '0; in_valid = 1'b1;
      t = 0;
      while ((n_out - base) < 65540 && t < 70000) begin
         @(posedge clk); #2;
         t++;
         if ((n_out - base) == 65534) chk("sat_fffe", 64'(xfer_cnt), 64'hFFFE);
         if ((n_out - base) == 65535) chk("sat_ffff", 64'(xfer_cnt), 64'hFFFF);
      end
      chk("sat_reach", 64'(n_out - base), 64'd65540);
      chk("sat_hold", 64'(xfer_cnt), 64'hFFFF);
      repeat (5) @(posedge clk);
      #2;
      chk("sat_hold2", 64'(xfer_cnt), 64'hFFFF);
      idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
